lvdc_timing_gen: RTL and testbench

//  Master timing generator. Drives the clk pins of the gate components (AND/expander

---
 rtl/lvdc_timing_gen_pkg.sv | 28 ++
 rtl/lvdc_timing_gen_if.sv | 30 +++
 rtl/lvdc_onehot_dec.sv | 26 ++
 rtl/lvdc_timing_gen.sv | 132 +++++++++++++
 tb/tb_lvdc_timing_gen.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lvdc_timing_gen_pkg.sv
// Shared definitions for the LVDC master timing generator: default
// geometry, state encoding and a counter-width helper.
package lvdc_timing_pkg;

  // Default timing geometry, reusable by consumers of the strobes
  localparam int NSUB_DEF  = 4;
  localparam int NBIT_DEF  = 14;
  localparam int NWORD_DEF = 3;

  // State encoding
  localparam logic [1:0] ST_HALT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STEP  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    HALT  = ST_HALT,
    RUN   = ST_RUN,
    STEP  = ST_STEP,
    DRAIN = ST_DRAIN
  } state_t;

  // Width of a counter holding 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lvdc_timing_gen_if.sv
// Strobe and control bundle between the timing generator (master)
// and the console / gate logic (slave).
interface lvdc_timing_gen_if
  import lvdc_timing_pkg::*;
#(
  parameter int NSUB  = NSUB_DEF,
  parameter int NBIT  = NBIT_DEF,
  parameter int NWORD = NWORD_DEF
) ();

  logic             run;
  logic             step;
  logic [NSUB-1:0]  ph;
  logic [NBIT-1:0]  bt;
  logic [NWORD-1:0] wt;
  logic             eow;
  logic             eoc;
  logic             halted;

  modport master (
    input  run, step,
    output ph, bt, wt, eow, eoc, halted
  );

  modport slave (
    output run, step,
    input  ph, bt, wt, eow, eoc, halted
  );

endinterface

// File: rtl/lvdc_onehot_dec.sv
// Binary index to one-hot decoder with an enable; output is all-zero
// when the enable is low.
module lvdc_onehot_dec
  import lvdc_timing_pkg::*;
#(
  parameter int N = 4,
  parameter int W = cnt_width(N)
) (
  input  logic [W-1:0] idx,
  input  logic         en,
  output logic [N-1:0] y
);

  // Raise exactly the bit selected by idx while enabled
  always_comb begin
    y = '0;
    for (int i = 0; i < N; i++) begin
      if (en && (idx == W'(i))) begin
        y[i] = 1'b1;
      end else begin
        y[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/lvdc_timing_gen.sv
// Master timing generator: run/halt/step FSM plus cascaded phase, bit
// and word counters. All strobes are decodes of registered state, so
// run/step never reach an output combinationally.
module lvdc_timing_gen
  import lvdc_timing_pkg::*;
#(
  parameter int NSUB  = NSUB_DEF,
  parameter int NBIT  = NBIT_DEF,
  parameter int NWORD = NWORD_DEF
) (
  input logic                clk,
  input logic                rst,
  lvdc_timing_gen_if.master  bus
);

  localparam int SW = cnt_width(NSUB);
  localparam int BW = cnt_width(NBIT);
  localparam int WW = cnt_width(NWORD);

  state_t        state_r;
  state_t        state_nx;
  logic [SW-1:0] sub_r;
  logic [BW-1:0] bit_idx_r;
  logic [WW-1:0] wrd_r;

  logic active_s;
  logic sub_last_s;
  logic bit_last_s;
  logic wrd_last_s;
  logic eow_s;
  logic run_s;
  logic step_s;

  assign run_s      = bus.run;
  assign step_s     = bus.step;
  assign active_s   = (state_r != HALT);
  assign sub_last_s = (sub_r == SW'(NSUB - 1));
  assign bit_last_s = (bit_idx_r == BW'(NBIT - 1));
  assign wrd_last_s = (wrd_r == WW'(NWORD - 1));
  assign eow_s      = active_s & sub_last_s & bit_last_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= HALT;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next state: halts only ever take effect on an end-of-word edge
  always_comb begin
    state_nx = state_r;
    case (state_r)
      HALT: begin
        if (run_s) begin
          state_nx = RUN;
        end else if (step_s) begin
          state_nx = STEP;
        end else begin
          state_nx = HALT;
        end
      end
      RUN: begin
        if (!run_s) begin
          state_nx = eow_s ? HALT : DRAIN;
        end else begin
          state_nx = RUN;
        end
      end
      DRAIN: begin
        if (run_s) begin
          state_nx = RUN;
        end else if (eow_s) begin
          state_nx = HALT;
        end else begin
          state_nx = DRAIN;
        end
      end
      STEP: begin
        if (eow_s) begin
          state_nx = run_s ? RUN : HALT;
        end else begin
          state_nx = STEP;
        end
      end
      default: begin
        state_nx = HALT;
      end
    endcase
  end

  // Cascaded counters; frozen while halted so a restart resumes at the next word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_r     <= '0;
      bit_idx_r <= '0;
      wrd_r     <= '0;
    end else if (active_s) begin
      sub_r <= sub_last_s ? '0 : sub_r + SW'(1);
      if (sub_last_s) begin
        bit_idx_r <= bit_last_s ? '0 : bit_idx_r + BW'(1);
      end
      if (sub_last_s && bit_last_s) begin
        wrd_r <= wrd_last_s ? '0 : wrd_r + WW'(1);
      end
    end
  end

  lvdc_onehot_dec #(.N(NSUB), .W(SW)) u_ph_dec (
    .idx (sub_r),
    .en  (active_s),
    .y   (bus.ph)
  );

  lvdc_onehot_dec #(.N(NBIT), .W(BW)) u_bt_dec (
    .idx (bit_idx_r),
    .en  (active_s),
    .y   (bus.bt)
  );

  lvdc_onehot_dec #(.N(NWORD), .W(WW)) u_wt_dec (
    .idx (wrd_r),
    .en  (active_s),
    .y   (bus.wt)
  );

  assign bus.eow    = eow_s;
  assign bus.eoc    = eow_s & wrd_last_s;
  assign bus.halted = ~active_s;

endmodule

// File: tb/tb_lvdc_timing_gen.sv
// Self-checking bench for lvdc_timing_gen. The reference model tracks a
// single linear position within the cycle plus an "active" and a
// "stepping" flag; strobes are derived from that position arithmetically.
module tb_lvdc_timing_gen;
  import lvdc_timing_pkg::*;

  localparam int NS  = 4;
  localparam int NB  = 14;
  localparam int NW  = 3;
  localparam int WL  = NS * NB;
  localparam int TOT = WL * NW;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  lvdc_timing_gen_if #(.NSUB(NS), .NBIT(NB), .NWORD(NW)) bus ();
  lvdc_timing_gen #(.NSUB(NS), .NBIT(NB), .NWORD(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  lvdc_timing_gen_if #(.NSUB(2), .NBIT(3), .NWORD(1)) bus2 ();
  lvdc_timing_gen #(.NSUB(2), .NBIT(3), .NWORD(1)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  int errors = 0;
  int checks = 0;

  // reference model
  bit m_active;
  bit m_step;
  int m_pos;
  logic [NS-1:0] e_ph;
  logic [NB-1:0] e_bt;
  logic [NW-1:0] e_wt;
  logic e_eow, e_eoc, e_halted;

  task automatic model_expect();
    e_ph = '0; e_bt = '0; e_wt = '0;
    if (m_active) begin
      e_ph[m_pos % NS]        = 1'b1;
      e_bt[(m_pos / NS) % NB] = 1'b1;
      e_wt[m_pos / WL]        = 1'b1;
    end
    e_eow    = m_active && ((m_pos % WL) == WL - 1);
    e_eoc    = e_eow && ((m_pos / WL) == NW - 1);
    e_halted = !m_active;
  endtask

  // One rising edge: halts only happen at end of word when run is low
  task automatic model_edge(input bit r, input bit s);
    bit eow_now;
    eow_now = m_active && ((m_pos % WL) == WL - 1);
    if (!m_active) begin
      if (r) begin
        m_active = 1'b1; m_step = 1'b0;
      end else if (s) begin
        m_active = 1'b1; m_step = 1'b1;
      end
    end else begin
      m_pos = (m_pos + 1) % TOT;
      if (eow_now) begin
        if (r) m_step = 1'b0;
        else   m_active = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_step = 1'b0; m_pos = 0;
    model_expect();
  endtask

  task automatic cycle(input bit r, input bit s);
    @(negedge clk);
    bus.run  = r;
    bus.step = s;
    @(posedge clk);
    model_edge(r, s);
    #1;
    model_expect();
  endtask

  task automatic do_reset();
    bus.run = 1'b0; bus.step = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.run = 1'b0; bus.step = 1'b0;
    #1;
    checks++;
    if ({bus.ph, bus.bt, bus.wt, bus.eow, bus.eoc, bus.halted} !== {4'b0, 14'b0, 3'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_hold: got ph=%b bt=%b wt=%b eow=%b eoc=%b halted=%b", bus.ph, bus.bt, bus.wt, bus.eow, bus.eoc, bus.halted);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0);
    checks++;
    if (bus.ph === 4'b0) begin
      errors++;
      $display("FAIL reset_pre_running: got ph=%b want nonzero", bus.ph);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.ph, bus.bt, bus.wt, bus.eow, bus.eoc, bus.halted} !== {4'b0, 14'b0, 3'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_async: got ph=%b bt=%b wt=%b eow=%b eoc=%b halted=%b", bus.ph, bus.bt, bus.wt, bus.eow, bus.eoc, bus.halted);
    end
    bus.run = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(1'b1, 1'b0);
    checks++;
    if ({bus.ph, bus.bt, bus.wt} !== {4'b0001, 14'b1, 3'b001}) begin
      errors++;
      $display("FAIL reset_restart: got ph=%b bt=%b wt=%b want 0001/..1/001", bus.ph, bus.bt, bus.wt);
    end
  endtask

  task automatic test_free_run();
    int last_eow, last_eoc, n_eow, bt1_first;
    logic [NW-1:0] wseq[$];
    do_reset();
    last_eow = -1; last_eoc = -1; n_eow = 0; bt1_first = -1;
    for (int i = 0; i < 340; i++) begin
      cycle(1'b1, 1'b0);
      checks++;
      if ({bus.ph, bus.bt, bus.wt, bus.eow, bus.eoc, bus.halted} !== {e_ph, e_bt, e_wt, e_eow, e_eoc, e_halted}) begin
        errors++;
        $display("FAIL free_run cyc %0d: got %h want %h", i, {bus.ph, bus.bt, bus.wt, bus.eow, bus.eoc, bus.halted}, {e_ph, e_bt, e_wt, e_eow, e_eoc, e_halted});
      end
      if (bus.bt[1] === 1'b1 && bt1_first < 0) bt1_first = i;
      if (wseq.size() == 0 || wseq[$] !== bus.wt) wseq.push_back(bus.wt);
      if (bus.eow === 1'b1) begin
        n_eow++;
        if (last_eow >= 0) begin
          checks++;
          if (i - last_eow != WL) begin
            errors++;
            $display("FAIL eow_period: got %0d want %0d", i - last_eow, WL);
          end
        end
        last_eow = i;
      end
      if (bus.eoc === 1'b1) begin
        if (last_eoc >= 0) begin
          checks++;
          if (i - last_eoc != TOT) begin
            errors++;
            $display("FAIL eoc_period: got %0d want %0d", i - last_eoc, TOT);
          end
        end
        last_eoc = i;
      end
    end
    checks++;
    if (bt1_first != NS) begin
      errors++;
      $display("FAIL bt1_first_rise: got cycle %0d want %0d", bt1_first, NS);
    end
    checks++;
    if (n_eow != 6) begin
      errors++;
      $display("FAIL eow_count: got %0d want 6", n_eow);
    end
    checks++;
    if (wseq.size() < 4 || wseq[0] !== 3'b001 || wseq[1] !== 3'b010 || wseq[2] !== 3'b100 || wseq[3] !== 3'b001) begin
      errors++;
      $display("FAIL wt_order: got %0d entries, first %b want 001,010,100,001", wseq.size(), wseq.size() > 0 ? wseq[0] : 3'bx);
    end
  endtask

  task automatic test_halt_drain();
    int n;
    bit saw_eow, done;
    do_reset();
    for (int i = 0; i < 21; i++) cycle(1'b1, 1'b0);
    n = 0; saw_eow = 1'b0; done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      cycle(1'b0, 1'b0);
      n++;
      checks++;
      if ({bus.ph, bus.bt, bus.wt, bus.eow, bus.eoc, bus.halted} !== {e_ph, e_bt, e_wt, e_eow, e_eoc, e_halted}) begin
        errors++;
        $display("FAIL halt_drain cyc %0d: got %h want %h", i, {bus.ph, bus.bt, bus.wt, bus.eow, bus.eoc, bus.halted}, {e_ph, e_bt, e_wt, e_eow, e_eoc, e_halted});
      end
      if (bus.eow === 1'b1) saw_eow = 1'b1;
      if (bus.halted === 1'b1) done = 1'b1;
    end
    checks++;
    if (!done || !saw_eow || n != WL - 20) begin
      errors++;
      $display("FAIL halt_drain_end: got halted=%0d eow_seen=%0d edges=%0d want 1/1/%0d", done, saw_eow, n, WL - 20);
    end
    cycle(1'b1, 1'b0);
    checks++;
    if ({bus.ph, bus.bt, bus.wt} !== {4'b0001, 14'b1, 3'b010}) begin
      errors++;
      $display("FAIL halt_restart_wt: got ph=%b bt=%b wt=%b want wt=010", bus.ph, bus.bt, bus.wt);
    end
  endtask

  task automatic test_single_step();
    int n_act, n_eow;
    bit done;
    do_reset();
    cycle(1'b0, 1'b1);
    n_act = (bus.ph !== 4'b0) ? 1 : 0;
    n_eow = 0; done = 1'b0;
    for (int j = 0; j < 120 && !done; j++) begin
      cycle(1'b0, j == 20);
      checks++;
      if ({bus.ph, bus.bt, bus.wt, bus.eow, bus.eoc, bus.halted} !== {e_ph, e_bt, e_wt, e_eow, e_eoc, e_halted}) begin
        errors++;
        $display("FAIL single_step cyc %0d: got %h want %h", j, {bus.ph, bus.bt, bus.wt, bus.eow, bus.eoc, bus.halted}, {e_ph, e_bt, e_wt, e_eow, e_eoc, e_halted});
      end
      if (bus.ph !== 4'b0) n_act++;
      if (bus.eow === 1'b1) n_eow++;
      if (bus.halted === 1'b1) done = 1'b1;
    end
    checks++;
    if (!done || n_act != WL || n_eow != 1) begin
      errors++;
      $display("FAIL step_length: got halted=%0d active=%0d eow=%0d want 1/%0d/1", done, n_act, n_eow, WL);
    end
    for (int j = 0; j < 5; j++) cycle(1'b0, 1'b0);
    checks++;
    if (bus.halted !== 1'b1 || bus.ph !== 4'b0) begin
      errors++;
      $display("FAIL step_stays_halted: got halted=%b ph=%b want 1/0000", bus.halted, bus.ph);
    end
    cycle(1'b0, 1'b1);
    checks++;
    if (bus.wt !== 3'b010 || bus.ph !== 4'b0001) begin
      errors++;
      $display("FAIL step_next_word: got wt=%b ph=%b want 010/0001", bus.wt, bus.ph);
    end
  endtask

  task automatic test_priority_rerun();
    int gaps, halts;
    do_reset();
    cycle(1'b1, 1'b1);
    gaps = 0; halts = 0;
    for (int j = 0; j < 80; j++) begin
      cycle(!(j >= 70 && j < 73), 1'b0);
      checks++;
      if ({bus.ph, bus.bt, bus.wt, bus.eow, bus.eoc, bus.halted} !== {e_ph, e_bt, e_wt, e_eow, e_eoc, e_halted}) begin
        errors++;
        $display("FAIL priority cyc %0d: got %h want %h", j, {bus.ph, bus.bt, bus.wt, bus.eow, bus.eoc, bus.halted}, {e_ph, e_bt, e_wt, e_eow, e_eoc, e_halted});
      end
      if (bus.ph === 4'b0) gaps++;
      if (bus.halted !== 1'b0) halts++;
    end
    checks++;
    if (gaps != 0 || halts != 0) begin
      errors++;
      $display("FAIL rerun_no_gap: got gaps=%0d halted_cycles=%0d want 0/0", gaps, halts);
    end
  endtask

  task automatic test_random();
    bit r, s;
    do_reset();
    r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) r = !r;
      s = ($urandom_range(0, 99) < 5);
      cycle(r, s);
      checks++;
      if ({bus.ph, bus.bt, bus.wt, bus.eow, bus.eoc, bus.halted} !== {e_ph, e_bt, e_wt, e_eow, e_eoc, e_halted}) begin
        errors++;
        $display("FAIL random cyc %0d: got %h want %h", i, {bus.ph, bus.bt, bus.wt, bus.eow, bus.eoc, bus.halted}, {e_ph, e_bt, e_wt, e_eow, e_eoc, e_halted});
      end
    end
  endtask

  task automatic test_param_sweep();
    int last_eow;
    checks++;
    if (bus2.halted !== 1'b1 || bus2.ph !== 2'b0) begin
      errors++;
      $display("FAIL sweep_reset: got halted=%b ph=%b want 1/00", bus2.halted, bus2.ph);
    end
    @(negedge clk);
    rst2 = 1'b0;
    bus2.run = 1'b1;
    last_eow = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus2.wt !== 1'b1 || bus2.eoc !== bus2.eow || bus2.halted !== 1'b0) begin
        errors++;
        $display("FAIL sweep_wt_eoc cyc %0d: got wt=%b eow=%b eoc=%b halted=%b", i, bus2.wt, bus2.eow, bus2.eoc, bus2.halted);
      end
      if (bus2.eow === 1'b1) begin
        checks++;
        if ((last_eow < 0 && i != 5) || (last_eow >= 0 && i - last_eow != 6)) begin
          errors++;
          $display("FAIL sweep_eow_period: got eow at %0d (prev %0d) want first 5, period 6", i, last_eow);
        end
        last_eow = i;
      end
    end
    checks++;
    if (last_eow != 35) begin
      errors++;
      $display("FAIL sweep_eow_last: got %0d want 35", last_eow);
    end
    @(negedge clk);
    bus2.run = 1'b0;
  endtask

  initial begin
    rst2 = 1'b1;
    bus2.run = 1'b0;
    bus2.step = 1'b0;
    test_reset();
    test_free_run();
    test_halt_drain();
    test_single_step();
    test_priority_rerun();
    test_random();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
